mips_store_buffer: RTL
======================

Name: mips_store_buffer

Overview:
- Posted-write buffer between the pipelined MIPS memory stage and data memory.
- Captures each store (memwrite, dataadr, writedata) into an in-order FIFO and drains it to data memory over a req/ack handshake.
- Forwards buffered data to loads that hit an address still in the buffer.
- Stalls the pipeline only when the buffer is full.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- memwrite  input  1  store request from the memory stage, one cycle per store.
- dataadr  input  AW  store address.
- writedata  input  DW  store data.
- ld_addr  input  AW  current load address from the memory stage.
- stall  output  1  buffer full; the pipeline must hold the store.
- fwd_hit  output  1  ld_addr matches a buffered entry.
- fwd_data  output  DW  data of the youngest matching entry.
- empty  output  1  no entries held; used as the fence/drain-complete flag.
- mem_req  output  1  write request to data memory.
- mem_addr  output  AW  head entry address.
- mem_wdata  output  DW  head entry data.
- mem_ack  input  1  data memory accepted the write.

Behaviour:
- Reset (reset=0, asynchronous):
  - all entries invalid, pointers and count = 0, FSM in IDLE.
  - mem_req=0, stall=0, empty=1, fwd_hit=0.
  - mem_addr and mem_wdata = 0.
  - Asserting reset mid-handshake drops mem_req immediately and discards all entries.
- Push: memwrite=1 && !stall writes {dataadr, writedata} at the tail on the clock edge.
- stall = (count == DEPTH), taken from registered state (combinationally from count).
  - A store presented while stall=1 is ignored; the pipeline re-presents it.
  - No same-cycle bypass of a pop into a full buffer.
- Drain FSM:
  - IDLE: mem_req=0. Goes to REQ on the edge where count becomes or remains non-zero, so the first request appears 1 cycle after the push edge.
  - REQ: mem_req=1; mem_addr/mem_wdata show the head entry and stay stable until mem_ack.
    - On mem_ack, pop the head.
    - If the remaining count (after any same-cycle push) is 0, go to IDLE; otherwise stay in REQ with the next head on the following cycle.
    - Back-to-back acks therefore drain one entry per cycle.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Forwarding:
  - Combinational compare of ld_addr[AW-1:2] against all valid entries' address[AW-1:2].
  - fwd_data is the youngest matching entry in tail order.
  - The entry being popped in the current cycle still counts as valid.
  - A store pushed in the current cycle is not visible until the next cycle.
- Ordering: memory writes leave strictly in program order; no reordering.
- mem_ack outside REQ is ignored.
- empty = (count == 0).

Optional Feature:
- Macro: MIPS_STORE_BUFFER_COALESCE_EN.
- Defined: a push whose word address equals the youngest valid entry's word address overwrites that entry's data instead of allocating a new one.
  - No coalescing when the youngest entry is the head in REQ, to protect data stability.
  - Coalescing applies even when stall=1 (a coalescing store is accepted while full), so stall is suppressed for that store.
- Undefined: every accepted store allocates a new entry.

Decomposition:
- Shared package mips_pkg:
  - typedef sb_entry_t {addr[AW-1:0], data[DW-1:0]}.
  - enum sb_state_t {SB_IDLE, SB_REQ}.
  - localparam WORD_OFS = 2.
- One natural sub-module, sb_fwd_match: a priority matcher over DEPTH entries that returns hit and youngest index, given the valid vector and tail pointer.

Test Plan:
- Store 0x7 to 0x50, mem_ack tied 1 → mem_req rises 1 cycle after the push edge with mem_addr=0x50, mem_wdata=0x7; empty=1 after the ack edge.
- Hold mem_ack=0 and push 4 stores (0x54..0x60, data 1..4) → stall=1 after the 4th; a 5th store is ignored; release ack → writes leave in order 0x54, 0x58, 0x5C, 0x60, one per cycle.
- Buffer 0x80→0xA then 0x80→0xB, ld_addr=0x80 → fwd_hit=1, fwd_data=0xB; ld_addr=0x84 → fwd_hit=0.
- Push and ack in the same cycle with count=2 → count stays 2, pointers wrap correctly across 3×DEPTH stores; the data sequence matches a reference queue.
- Assert reset low while mem_req=1 with 3 entries → mem_req=0 immediately; empty=1; no further writes after reset is released.
- With MIPS_STORE_BUFFER_COALESCE_EN and ack=0: two stores to 0x90 (0x1, then 0x2) behind a head at 0x50 → count=2; drain writes 0x50, then 0x90=0x2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MIPS store buffer: the entry record, drain FSM states and word offset.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  // Entry widths; the buffer's AW/DW parameters default to these.
  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  // Byte-offset bits dropped when comparing word addresses.
  localparam int WORD_OFS = 2;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Priority matcher: finds the youngest valid entry whose address matched the load.
// Latency: combinational.
// Backpressure: none.
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] addr_eq,
  input  logic [PW-1:0]    tail,
  output logic             hit,
  output logic [PW-1:0]    idx
);

  logic [PW-1:0] k;

  // Walk from the oldest slot (tail) to the youngest (tail-1); the last match wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    k   = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      k = tail - PW'(i);
      if (valid[k] && addr_eq[k]) begin
        hit = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/mips_store_buffer.sv
// Posted-write buffer: in-order store FIFO drained to data memory by req/ack, with load forwarding.
// Latency: mem_req rises one cycle after the push edge; one entry drains per acked cycle.
// Backpressure: stall while full; optional MIPS_STORE_BUFFER_COALESCE_EN merges a store into the youngest entry.
module mips_store_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  input  logic [AW-1:0] ld_addr,
  output logic          stall,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          empty,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  sb_entry_t        ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_n;
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      cnt_q, cnt_n;
  sb_state_t        state_q, state_n;
  logic             pop, push, coal;
  logic [DEPTH-1:0] addr_eq;
  logic             match_hit;
  logic [PW-1:0]    match_idx;
  logic             ld_addr_unused;

  // Byte-select bits of the load address never take part in forwarding.
  assign ld_addr_unused = &{1'b0, ld_addr[WORD_OFS-1:0]};

  // Head leaves only while a request is outstanding and memory acks it.
  assign pop = (state_q == SB_REQ) && mem_ack;

`ifdef MIPS_STORE_BUFFER_COALESCE_EN
  logic [PW-1:0] young;
  assign young = tail_q - PW'(1);
  // Merge into the youngest entry unless it is the head currently on the bus.
  assign coal = memwrite && (cnt_q != '0) && vld_q[young] &&
                (ent_q[young].addr[AW-1:WORD_OFS] == dataadr[AW-1:WORD_OFS]) &&
                !((state_q == SB_REQ) && (young == head_q));
`else
  assign coal = 1'b0;
`endif

  assign stall = (cnt_q == FULL) && !coal;
  assign push  = memwrite && !stall && !coal;
  assign empty = (cnt_q == '0);

  // Occupancy and valid bits after this edge's push/pop.
  always_comb begin
    cnt_n = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    vld_n = vld_q;
    if (pop)  vld_n[head_q] = 1'b0;
    if (push) vld_n[tail_q] = 1'b1;
  end

  // Pointers, count and valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      cnt_q <= cnt_n;
      vld_q <= vld_n;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
    end
  end

  // Entry payloads; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) ent_q[tail_q] <= '{addr: dataadr, data: writedata};
`ifdef MIPS_STORE_BUFFER_COALESCE_EN
    if (coal) ent_q[young].data <= writedata;
`endif
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SB_IDLE;
    else        state_q <= state_n;
  end

  // Drain FSM next state: request whenever anything remains after this edge.
  always_comb begin
    state_n = state_q;
    case (state_q)
      SB_IDLE: if (cnt_n != '0)         state_n = SB_REQ;
      SB_REQ:  if (pop && cnt_n == '0)  state_n = SB_IDLE;
      default:                          state_n = SB_IDLE;
    endcase
  end

  // Drain FSM outputs: head entry on the bus only while requesting.
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == SB_REQ) begin
      mem_req   = 1'b1;
      mem_addr  = ent_q[head_q].addr;
      mem_wdata = ent_q[head_q].data;
    end
  end

  // Word-address compare of the load against every valid entry.
  always_comb begin
    addr_eq = '0;
    for (int j = 0; j < DEPTH; j++) begin
      addr_eq[j] = ent_q[j].addr[AW-1:WORD_OFS] == ld_addr[AW-1:WORD_OFS];
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd_match (
    .valid   (vld_q),
    .addr_eq (addr_eq),
    .tail    (tail_q),
    .hit     (match_hit),
    .idx     (match_idx)
  );

  assign fwd_hit  = match_hit;
  assign fwd_data = match_hit ? ent_q[match_idx].data : '0;

endmodule
